// File: rtl/l2_line_mover.sv
// rtl/l2_line_mover.sv - L2 line transfer engine: 4-beat memory fills into one
// RAM way, and victim writebacks from one RAM way streamed out as 4 beats.
module l2_line_mover (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         fill_req,
   input  logic [1:0]   fill_way,
   input  logic [8:0]   fill_index,
   input  logic         wb_req,
   input  logic [1:0]   wb_way,
   input  logic [8:0]   wb_index,
   output logic         busy,
   output logic         done,
   input  logic [127:0] mem_rdata,
   input  logic         mem_rvalid,
   output logic [127:0] mem_wdata,
   output logic         mem_wvalid,
   input  logic         mem_wready,
   output logic         l2_data0_rw,
   output logic         l2_data1_rw,
   output logic         l2_data2_rw,
   output logic         l2_data3_rw,
   output logic [8:0]   l2_index,
   output logic [511:0] l2_data_wd,
   input  logic [511:0] l2_data0_rd,
   input  logic [511:0] l2_data1_rd,
   input  logic [511:0] l2_data2_rd,
   input  logic [511:0] l2_data3_rd
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_FILL_WR = 3'd2,
      S_WB_RD   = 3'd3,
      S_WB_CAP  = 3'd4,
      S_WB_SEND = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [1:0]     beat_cnt_q, beat_cnt_d;
   logic [1:0]     way_q, way_d;
   logic [8:0]     index_q, index_d;
   logic [511:0]   line_q, line_d;
   logic           done_q, done_d;
   logic [511:0]   rd_sel;
   logic [8:0]     beat_lsb;

   // One buffer serves both directions: fill assembly and writeback capture.
   assign beat_lsb = {beat_cnt_q, 7'b0000000};

   always_comb begin
      rd_sel = l2_data0_rd;
      case (way_q)
         2'd0:    rd_sel = l2_data0_rd;
         2'd1:    rd_sel = l2_data1_rd;
         2'd2:    rd_sel = l2_data2_rd;
         default: rd_sel = l2_data3_rd;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      way_d      = way_q;
      index_d    = index_q;
      line_d     = line_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Writeback wins so the victim leaves before a fill can replace it.
            if (wb_req) begin
               state_d    = S_WB_RD;
               way_d      = wb_way;
               index_d    = wb_index;
               beat_cnt_d = 2'd0;
            end else if (fill_req) begin
               state_d    = S_FILL;
               way_d      = fill_way;
               index_d    = fill_index;
               beat_cnt_d = 2'd0;
            end
         end
         S_FILL: begin
            if (mem_rvalid) begin
               line_d[beat_lsb +: 128] = mem_rdata;
               beat_cnt_d              = beat_cnt_q + 2'd1;
               if (beat_cnt_q == 2'd3) begin
                  state_d = S_FILL_WR;
               end
            end
         end
         S_FILL_WR: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         S_WB_RD: begin
            state_d = S_WB_CAP;
         end
         S_WB_CAP: begin
            line_d     = rd_sel;
            beat_cnt_d = 2'd0;
            state_d    = S_WB_SEND;
         end
         S_WB_SEND: begin
            if (mem_wready) begin
               beat_cnt_d = beat_cnt_q + 2'd1;
               if (beat_cnt_q == 2'd3) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         beat_cnt_q <= 2'd0;
         way_q      <= 2'd0;
         index_q    <= 9'd0;
         line_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         way_q      <= way_d;
         index_q    <= index_d;
         line_q     <= line_d;
         done_q     <= done_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign l2_index    = busy ? index_q : 9'd0;
   assign l2_data_wd  = (state_q == S_FILL_WR) ? line_q : '0;
   assign l2_data0_rw = (state_q == S_FILL_WR) && (way_q == 2'd0);
   assign l2_data1_rw = (state_q == S_FILL_WR) && (way_q == 2'd1);
   assign l2_data2_rw = (state_q == S_FILL_WR) && (way_q == 2'd2);
   assign l2_data3_rw = (state_q == S_FILL_WR) && (way_q == 2'd3);
   assign mem_wvalid  = (state_q == S_WB_SEND);
   assign mem_wdata   = mem_wvalid ? line_q[beat_lsb +: 128] : '0;

endmodule

// File: tb/tb_l2_line_mover.sv
// tb/tb_l2_line_mover.sv - scoreboard bench for l2_line_mover: RAM writes and
// writeback beats are checked against queued expectations.
module tb_l2_line_mover;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         fill_req = 1'b0;
   logic [1:0]   fill_way = 2'd0;
   logic [8:0]   fill_index = 9'd0;
   logic         wb_req = 1'b0;
   logic [1:0]   wb_way = 2'd0;
   logic [8:0]   wb_index = 9'd0;
   logic         busy, done;
   logic [127:0] mem_rdata = '0;
   logic         mem_rvalid = 1'b0;
   logic [127:0] mem_wdata;
   logic         mem_wvalid;
   logic         mem_wready = 1'b0;
   logic         l2_data0_rw, l2_data1_rw, l2_data2_rw, l2_data3_rw;
   logic [8:0]   l2_index;
   logic [511:0] l2_data_wd;
   logic [511:0] l2_data0_rd = '0, l2_data1_rd = '0, l2_data2_rd = '0, l2_data3_rd = '0;

   typedef struct {
      logic [1:0]   way;
      logic [8:0]   index;
      logic [511:0] data;
   } wr_t;

   wr_t          exp_wr[$];
   logic [127:0] exp_beat[$];
   int           n_cmp = 0;
   int           n_fail = 0;
   int           rw_pulses = 0;

   l2_line_mover dut (
      .clk(clk), .rst_n(rst_n),
      .fill_req(fill_req), .fill_way(fill_way), .fill_index(fill_index),
      .wb_req(wb_req), .wb_way(wb_way), .wb_index(wb_index),
      .busy(busy), .done(done),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .l2_data0_rw(l2_data0_rw), .l2_data1_rw(l2_data1_rw),
      .l2_data2_rw(l2_data2_rw), .l2_data3_rw(l2_data3_rw),
      .l2_index(l2_index), .l2_data_wd(l2_data_wd),
      .l2_data0_rd(l2_data0_rd), .l2_data1_rd(l2_data1_rd),
      .l2_data2_rd(l2_data2_rd), .l2_data3_rd(l2_data3_rd)
   );

   always #5 clk = ~clk;

   // Every 32-bit word is tagged with way, word number and set.
   function automatic logic [511:0] ram_pat(input int w, input logic [8:0] idx);
      logic [511:0] r;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         r[k*32 +: 32] = {4'(w), 4'(k), 15'h2A5A, idx};
      end
      return r;
   endfunction

   // RAM model: read data appears one cycle after the address.
   always @(posedge clk) begin
      l2_data0_rd <= ram_pat(0, l2_index);
      l2_data1_rd <= ram_pat(1, l2_index);
      l2_data2_rd <= ram_pat(2, l2_index);
      l2_data3_rd <= ram_pat(3, l2_index);
   end

   wr_t          mw;
   logic [127:0] mb;
   logic [3:0]   rw_vec;

   always @(negedge clk) begin
      if (rst_n) begin
         rw_vec = {l2_data3_rw, l2_data2_rw, l2_data1_rw, l2_data0_rw};
         if (rw_vec != 4'b0000) begin
            rw_pulses++;
            n_cmp++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: rw=%b index=%h, none expected", rw_vec, l2_index);
            end else begin
               mw = exp_wr.pop_front();
               if (rw_vec !== (4'b0001 << mw.way) || l2_index !== mw.index || l2_data_wd !== mw.data) begin
                  n_fail++;
                  $display("FAIL ram_write: rw=%b index=%h wd=%h want rw=%b index=%h wd=%h",
                           rw_vec, l2_index, l2_data_wd, 4'b0001 << mw.way, mw.index, mw.data);
               end
            end
         end
         if (mem_wvalid && mem_wready) begin
            n_cmp++;
            if (exp_beat.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_beat: wdata=%h, none expected", mem_wdata);
            end else begin
               mb = exp_beat.pop_front();
               if (mem_wdata !== mb) begin
                  n_fail++;
                  $display("FAIL wb_beat: got %h want %h", mem_wdata, mb);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wb(input int w, input logic [8:0] idx);
      logic [511:0] l;
      l = ram_pat(w, idx);
      for (int b = 0; b < 4; b++) exp_beat.push_back(l[b*128 +: 128]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, done, mem_wvalid, l2_data0_rw, l2_data1_rw, l2_data2_rw, l2_data3_rw} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy/done/wvalid/rw=%b want 0", {busy, done, mem_wvalid,
                  l2_data0_rw, l2_data1_rw, l2_data2_rw, l2_data3_rw});
      end
      n_cmp++;
      if (l2_index !== 9'd0 || l2_data_wd !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_data: index=%h wdata=%h want 0", l2_index, mem_wdata);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill_b2b();
      logic [127:0] b[4];
      wr_t          e;
      int           base;
      for (int i = 0; i < 4; i++) b[i] = {96'hB0B1B2B3_C0C1C2C3_D0D1D2D3, 32'(i)};
      e.way = 2'd2; e.index = 9'h1A5; e.data = {b[3], b[2], b[1], b[0]};
      exp_wr.push_back(e);
      base = rw_pulses;
      fill_req = 1'b1; fill_way = 2'd2; fill_index = 9'h1A5;
      tick();
      fill_req = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || l2_index !== 9'h1A5) begin
         n_fail++;
         $display("FAIL fill_busy: busy=%b index=%h want 1 1a5", busy, l2_index);
      end
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1; mem_rdata = b[i];
         tick();
      end
      mem_rvalid = 1'b0;
      n_cmp++;
      if ({l2_data3_rw, l2_data2_rw, l2_data1_rw, l2_data0_rw} !== 4'b0100) begin
         n_fail++;
         $display("FAIL fill_pulse_cycle: rw=%b want 0100", {l2_data3_rw, l2_data2_rw, l2_data1_rw, l2_data0_rw});
      end
      tick();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || l2_data2_rw !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_done: done=%b busy=%b rw2=%b want 1 0 0", done, busy, l2_data2_rw);
      end
      tick();
      n_cmp++;
      if (done !== 1'b0 || rw_pulses != base + 1 || exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL fill_after: done=%b pulses=%0d pending=%0d want 0 1 0", done, rw_pulses - base, exp_wr.size());
      end
   endtask

   task automatic test_fill_gaps();
      int           pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      logic [127:0] b[4];
      wr_t          e;
      int           k, base;
      for (int i = 0; i < 4; i++) b[i] = {$urandom, $urandom, $urandom, $urandom};
      e.way = 2'd1; e.index = 9'h0C3; e.data = {b[3], b[2], b[1], b[0]};
      exp_wr.push_back(e);
      base = rw_pulses;
      k = 0;
      fill_req = 1'b1; fill_way = 2'd1; fill_index = 9'h0C3;
      tick();
      fill_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         mem_rvalid = (pat[i] == 1);
         if (pat[i] == 1) begin
            mem_rdata = b[k];
            k++;
         end else begin
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         end
         tick();
      end
      mem_rvalid = 1'b0;
      n_cmp++;
      if (rw_pulses != base || l2_data1_rw !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps_write_timing: early_pulses=%0d rw1=%b want 0 1", rw_pulses - base, l2_data1_rw);
      end
      tick();
      n_cmp++;
      if (rw_pulses != base + 1 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps_done: pulses=%0d done=%b want 1 1", rw_pulses - base, done);
      end
   endtask

   task automatic test_wb_backpressure();
      logic         prev_stall;
      logic [127:0] prev_data;
      int           hs;
      bit           seen_done;
      push_wb(1, 9'h003);
      wb_req = 1'b1; wb_way = 2'd1; wb_index = 9'h003;
      tick();
      wb_req = 1'b0;
      prev_stall = 1'b0; prev_data = '0; hs = 0; seen_done = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         mem_wready = (cyc % 2 == 1);
         @(negedge clk);
         n_cmp++;
         if (l2_index !== 9'h003) begin
            n_fail++;
            $display("FAIL wb_index: got %h want 003", l2_index);
         end
         if (prev_stall) begin
            n_cmp++;
            if (mem_wvalid !== 1'b1 || mem_wdata !== prev_data) begin
               n_fail++;
               $display("FAIL wb_stable: wvalid=%b wdata=%h want 1 %h", mem_wvalid, mem_wdata, prev_data);
            end
         end
         prev_stall = mem_wvalid && !mem_wready;
         prev_data  = mem_wdata;
         if (mem_wvalid && mem_wready) hs++;
         tick();
         if (done) begin
            seen_done = 1;
            break;
         end
      end
      mem_wready = 1'b0;
      n_cmp++;
      if (!seen_done || hs != 4 || exp_beat.size() != 0) begin
         n_fail++;
         $display("FAIL wb_complete: done_seen=%0d handshakes=%0d pending=%0d want 1 4 0", seen_done, hs, exp_beat.size());
      end
   endtask

   task automatic test_simultaneous();
      int base, lat;
      push_wb(0, 9'h055);
      base = rw_pulses;
      lat = -1;
      fill_req = 1'b1; fill_way = 2'd3; fill_index = 9'h0AA;
      wb_req = 1'b1; wb_way = 2'd0; wb_index = 9'h055;
      mem_wready = 1'b1;
      tick();
      fill_req = 1'b0; wb_req = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         mem_rvalid = 1'b1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         tick();
         if (done) begin
            lat = cyc;
            break;
         end
      end
      mem_rvalid = 1'b0; mem_wready = 1'b0;
      n_cmp++;
      if (lat != 6 || exp_beat.size() != 0) begin
         n_fail++;
         $display("FAIL simul_wb: accept_to_done=%0d pending=%0d want 6 0", lat, exp_beat.size());
      end
      repeat (6) tick();
      n_cmp++;
      if (rw_pulses != base || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_fill_dropped: pulses=%0d busy=%b want 0 0", rw_pulses - base, busy);
      end
   endtask

   task automatic test_reset_midop();
      int base;
      base = rw_pulses;
      fill_req = 1'b1; fill_way = 2'd0; fill_index = 9'h10F;
      tick();
      fill_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_rvalid = 1'b1; mem_rdata = {4{32'h600D0000 | i}};
         tick();
      end
      mem_rvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || l2_index !== 9'd0 || done !== 1'b0 || l2_data_wd !== '0) begin
         n_fail++;
         $display("FAIL midop_reset_outputs: busy=%b index=%h done=%b want 0 0 0", busy, l2_index, done);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 2; i < 4; i++) begin
         mem_rvalid = 1'b1; mem_rdata = {4{32'h600D0000 | i}};
         tick();
      end
      mem_rvalid = 1'b0;
      repeat (6) tick();
      n_cmp++;
      if (rw_pulses != base || busy !== 1'b0 || l2_index !== 9'd0 || mem_wvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_no_write: pulses=%0d busy=%b index=%h wvalid=%b want 0 0 0 0",
                  rw_pulses - base, busy, l2_index, mem_wvalid);
      end
   endtask

   task automatic test_back_to_back();
      wr_t e;
      bit  seen_done;
      e.way = 2'd0; e.index = 9'h1FF; e.data = '0;
      for (int i = 0; i < 4; i++) e.data[i*128 +: 128] = {4{32'hFEED0000 | i}};
      exp_wr.push_back(e);
      fill_req = 1'b1; fill_way = 2'd0; fill_index = 9'h1FF;
      tick();
      fill_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1; mem_rdata = {4{32'hFEED0000 | i}};
         tick();
      end
      mem_rvalid = 1'b0;
      tick();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_fill_done: done=%b busy=%b want 1 0", done, busy);
      end
      push_wb(2, 9'h100);
      wb_req = 1'b1; wb_way = 2'd2; wb_index = 9'h100;
      mem_wready = 1'b1;
      tick();
      wb_req = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || l2_index !== 9'h100) begin
         n_fail++;
         $display("FAIL b2b_accept: busy=%b index=%h want 1 100", busy, l2_index);
      end
      seen_done = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         if (done) begin
            seen_done = 1;
            break;
         end
      end
      mem_wready = 1'b0;
      n_cmp++;
      if (!seen_done || exp_beat.size() != 0 || exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_wb: done_seen=%0d pending_beats=%0d pending_writes=%0d want 1 0 0",
                  seen_done, exp_beat.size(), exp_wr.size());
      end
   endtask

   initial begin
      test_reset();
      test_fill_b2b();
      test_fill_gaps();
      test_wb_backpressure();
      test_simultaneous();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, limit 200000 time units");
      $fatal(1);
   end

endmodule
